// File: rtl/octave_synth.sv
// Seven-octave square-wave voice generator. One shared phase accumulator feeds
// per-octave linear envelopes, which are summed into signed PCM behind valid/ready.
module octave_synth #(
  parameter int unsigned         SAMPLE_DIV = 1042,
  parameter int unsigned         PHASE_W    = 24,
  parameter logic [PHASE_W-1:0]  BASE_INC   = 24'd4810,
  parameter int unsigned         ENV_STEP   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  octaves,
  input  logic        octaves_en,
  output logic [15:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [6:0]  active_octaves,
  output logic        overrun
);

  localparam int unsigned      DIV_W    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [8:0]       STEP     = 9'(ENV_STEP);

  logic [6:0]         pending_q;
  logic [6:0]         active_q;
  logic [DIV_W-1:0]   div_cnt_q;
  logic [PHASE_W-1:0] acc_q;
  logic [7:0]         amp_q [7];
  logic [7:0]         amp_d [7];
  logic               tick_dly_q;
  logic [15:0]        sample_q;
  logic               sample_valid_q;
  logic               overrun_q;

  logic               tick;
  logic [8:0]         amp_up [7];
  logic [8:0]         amp_dn [7];
  logic signed [11:0] mix_sum;

  assign tick = (div_cnt_q == DIV_LAST);

  // 9-bit arithmetic exposes the carry/borrow used for saturation.
  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      amp_up[k] = {1'b0, amp_q[k]} + STEP;
      amp_dn[k] = {1'b0, amp_q[k]} - STEP;
      if (active_q[k]) amp_d[k] = amp_up[k][8] ? 8'hFF : amp_up[k][7:0];
      else             amp_d[k] = amp_dn[k][8] ? 8'h00 : amp_dn[k][7:0];
    end
  end

  // Octave k samples accumulator bit PHASE_W-1-k, doubling frequency per octave.
  always_comb begin
    mix_sum = '0;
    for (int k = 0; k < 7; k++) begin
      if (acc_q[PHASE_W-1-k]) mix_sum = mix_sum + $signed({4'b0000, amp_q[k]});
      else                    mix_sum = mix_sum - $signed({4'b0000, amp_q[k]});
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      active_q   <= '0;
      div_cnt_q  <= '0;
      acc_q      <= '0;
      tick_dly_q <= 1'b0;
    end else begin
      tick_dly_q <= tick;
      if (octaves_en) pending_q <= octaves;
      if (tick) begin
        div_cnt_q <= '0;
        acc_q     <= acc_q + BASE_INC;
        active_q  <= pending_q;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the envelope array is reset too, since a reset must silence every voice at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 7; k++) amp_q[k] <= '0;
    end else if (tick) begin
      for (int k = 0; k < 7; k++) amp_q[k] <= amp_d[k];
    end
  end

  // A load in the cycle after a tick wins over a plain transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else if (tick_dly_q) begin
      sample_q       <= {mix_sum, 4'b0000};
      sample_valid_q <= 1'b1;
      if (sample_valid_q && !sample_ready) overrun_q <= 1'b1;
    end else if (sample_valid_q && sample_ready) begin
      sample_valid_q <= 1'b0;
    end
  end

  assign sample         = sample_q;
  assign sample_valid   = sample_valid_q;
  assign active_octaves = active_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_octave_synth.sv
// Directed bench for octave_synth with SAMPLE_DIV=4, PHASE_W=8, BASE_INC=1, ENV_STEP=64.
// Edge numbering: edge 0 is the first rising edge with rst_n high.
module tb_octave_synth;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  octaves = '0;
  logic        octaves_en = 1'b0;
  logic        sample_ready = 1'b0;
  logic [15:0] sample;
  logic        sample_valid;
  logic [6:0]  active_octaves;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  int edge_no = -1;

  octave_synth #(
    .SAMPLE_DIV(4),
    .PHASE_W(8),
    .BASE_INC(8'd1),
    .ENV_STEP(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .octaves(octaves),
    .octaves_en(octaves_en),
    .sample(sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .active_octaves(active_octaves),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic run_to(input int e);
    int guard = 0;
    while (edge_no < e && guard < 1000) begin
      step();
      guard++;
    end
    checks++;
    if (edge_no != e) begin
      errors++;
      $display("FAIL run_to: at edge %0d, required edge %0d", edge_no, e);
    end
  endtask

  task automatic do_reset(input logic ready);
    rst_n = 1'b0;
    octaves_en = 1'b0;
    octaves = '0;
    sample_ready = ready;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edge_no = -1;
  endtask

  task automatic strobe_at_next_edge(input logic [6:0] mask);
    octaves = mask;
    octaves_en = 1'b1;
    step();
    octaves_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sample_ready = 1'b1;
    #23;
    checks++;
    if (sample !== 16'h0000) begin errors++; $display("FAIL rst_sample: got %h want 0000", sample); end
    checks++;
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", sample_valid); end
    checks++;
    if (active_octaves !== 7'h00) begin errors++; $display("FAIL rst_active: got %h want 00", active_octaves); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    @(negedge clk);
    rst_n = 1'b1;
    edge_no = -1;
    run_to(3);
    checks++;
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_no_early_valid: got %b want 0", sample_valid); end
    run_to(4);
    checks++;
    if (sample_valid !== 1'b1) begin errors++; $display("FAIL rst_first_valid: got %b want 1", sample_valid); end
    checks++;
    if (sample !== 16'h0000) begin errors++; $display("FAIL rst_first_sample: got %h want 0000", sample); end
    run_to(5);
    checks++;
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_consumed: got %b want 0", sample_valid); end
  endtask

  task automatic test_attack();
    logic [15:0] exp_s [4] = '{16'hFC00, 16'hF800, 16'hF400, 16'hF010};
    do_reset(1'b1);
    strobe_at_next_edge(7'h01);
    run_to(2);
    checks++;
    if (active_octaves !== 7'h00) begin errors++; $display("FAIL att_active_early: got %h want 00", active_octaves); end
    run_to(3);
    checks++;
    if (active_octaves !== 7'h01) begin errors++; $display("FAIL att_active: got %h want 01", active_octaves); end
    for (int i = 0; i < 4; i++) begin
      run_to(8 + 4 * i);
      checks++;
      if (sample_valid !== 1'b1 || sample !== exp_s[i]) begin
        errors++;
        $display("FAIL att_sample%0d: got v=%b s=%h want v=1 s=%h", i, sample_valid, sample, exp_s[i]);
      end
    end
  endtask

  task automatic test_release();
    logic [15:0] exp_s [4] = '{16'hF410, 16'hF810, 16'hFC10, 16'h0000};
    strobe_at_next_edge(7'h00);
    run_to(22);
    checks++;
    if (active_octaves !== 7'h01) begin errors++; $display("FAIL rel_active_early: got %h want 01", active_octaves); end
    run_to(23);
    checks++;
    if (active_octaves !== 7'h00) begin errors++; $display("FAIL rel_active: got %h want 00", active_octaves); end
    run_to(24);
    checks++;
    if (sample !== 16'hF010) begin errors++; $display("FAIL rel_hold_peak: got %h want F010", sample); end
    for (int i = 0; i < 4; i++) begin
      run_to(28 + 4 * i);
      checks++;
      if (sample_valid !== 1'b1 || sample !== exp_s[i]) begin
        errors++;
        $display("FAIL rel_sample%0d: got v=%b s=%h want v=1 s=%h", i, sample_valid, sample, exp_s[i]);
      end
    end
    run_to(44);
    checks++;
    if (sample !== 16'h0000) begin errors++; $display("FAIL rel_stays_zero: got %h want 0000", sample); end
  endtask

  task automatic test_back_pressure();
    do_reset(1'b0);
    strobe_at_next_edge(7'h01);
    run_to(4);
    checks++;
    if (sample_valid !== 1'b1 || sample !== 16'h0000 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got v=%b s=%h o=%b want v=1 s=0000 o=0", sample_valid, sample, overrun);
    end
    run_to(6);
    checks++;
    if (sample_valid !== 1'b1 || sample !== 16'h0000) begin
      errors++;
      $display("FAIL bp_stable: got v=%b s=%h want v=1 s=0000", sample_valid, sample);
    end
    run_to(8);
    checks++;
    if (sample_valid !== 1'b1 || sample !== 16'hFC00 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_overwrite: got v=%b s=%h o=%b want v=1 s=FC00 o=1", sample_valid, sample, overrun);
    end
    sample_ready = 1'b1;
    run_to(9);
    checks++;
    if (sample_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: got v=%b o=%b want v=0 o=1", sample_valid, overrun);
    end
    run_to(13);
    checks++;
    if (sample_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_sticky: got v=%b o=%b want v=0 o=1", sample_valid, overrun);
    end
  endtask

  task automatic test_coincident();
    do_reset(1'b0);
    strobe_at_next_edge(7'h01);
    run_to(2);
    strobe_at_next_edge(7'h7F);
    checks++;
    if (active_octaves !== 7'h01) begin errors++; $display("FAIL co_active_old: got %h want 01", active_octaves); end
    run_to(6);
    checks++;
    if (active_octaves !== 7'h01) begin errors++; $display("FAIL co_active_hold: got %h want 01", active_octaves); end
    run_to(7);
    checks++;
    if (active_octaves !== 7'h7F) begin errors++; $display("FAIL co_active_new: got %h want 7F", active_octaves); end
    sample_ready = 1'b1;
    run_to(8);
    checks++;
    if (sample_valid !== 1'b1 || overrun !== 1'b0 || sample !== 16'hFC00) begin
      errors++;
      $display("FAIL co_xfer_load: got v=%b o=%b s=%h want v=1 o=0 s=FC00", sample_valid, overrun, sample);
    end
    run_to(9);
    checks++;
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL co_drain: got %b want 0", sample_valid); end
    run_to(12);
    checks++;
    if (sample !== 16'hE800) begin errors++; $display("FAIL co_mix1: got %h want E800", sample); end
    run_to(16);
    checks++;
    if (sample !== 16'hD400) begin errors++; $display("FAIL co_mix2: got %h want D400", sample); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    strobe_at_next_edge(7'h01);
    run_to(8);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sample !== 16'h0000 || sample_valid !== 1'b0 || active_octaves !== 7'h00 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: got s=%h v=%b a=%h o=%b want all 0", sample, sample_valid, active_octaves, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sample_ready = 1'b1;
    edge_no = -1;
    run_to(3);
    checks++;
    if (sample_valid !== 1'b0 || active_octaves !== 7'h00) begin
      errors++;
      $display("FAIL async_restart_early: got v=%b a=%h want v=0 a=00", sample_valid, active_octaves);
    end
    run_to(4);
    checks++;
    if (sample_valid !== 1'b1 || sample !== 16'h0000) begin
      errors++;
      $display("FAIL async_restart_first: got v=%b s=%h want v=1 s=0000", sample_valid, sample);
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_release();
    test_back_pressure();
    test_coincident();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
